// File: rtl/tsn_tx_gate_sched.sv
// Two-class time-aware TX scheduler: gate cycle timer, TS window/guard band,
// frame-atomic TS/BE arbitration and frame/overrun statistics.
module tsn_tx_gate_sched #(
    parameter int unsigned NS_PER_CLK = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             tx_mac_aclk,
    input  logic             tx_mac_resetn,
    input  logic [63:0]      rtc_timer_in,
    input  logic             cfg_enable,
    input  logic [63:0]      cfg_base_time,
    input  logic [CNT_W-1:0] cfg_cycle_ns,
    input  logic [CNT_W-1:0] cfg_ts_start_ns,
    input  logic [CNT_W-1:0] cfg_ts_len_ns,
    input  logic [CNT_W-1:0] cfg_guard_ns,
    input  logic [7:0]       s_ts_tdata,
    input  logic             s_ts_tvalid,
    input  logic             s_ts_tlast,
    output logic             s_ts_tready,
    input  logic [7:0]       s_be_tdata,
    input  logic             s_be_tvalid,
    input  logic             s_be_tlast,
    output logic             s_be_tready,
    output logic [7:0]       m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready,
    output logic             ts_gate_open,
    output logic             be_gate_open,
    output logic             cycle_start,
    output logic [15:0]      ts_frame_cnt,
    output logic [15:0]      be_frame_cnt,
    output logic [15:0]      ts_overrun_cnt
);

    typedef enum logic [1:0] {IDLE, SEND_TS, SEND_BE} state_t;

    localparam logic [CNT_W:0] STEP = (CNT_W+1)'(NS_PER_CLK);

    state_t           state_q, state_d;
    logic             running_q, running_d;
    logic [CNT_W-1:0] cyc_ns_q, cyc_ns_d;
    logic             cycle_start_q, cycle_start_d;
    logic             gate_vld_q, gate_vld_d;
    logic             win_prev_q, win_prev_d;
    logic             ovr_seen_q, ovr_seen_d;
    logic [15:0]      ts_cnt_q, ts_cnt_d;
    logic [15:0]      be_cnt_q, be_cnt_d;
    logic [15:0]      ovr_cnt_q, ovr_cnt_d;

    logic [CNT_W:0]   cyc_ext, ts_end, next_ns;
    logic [CNT_W-1:0] guard_lo;
    logic             in_win, in_guard, ts_open, be_open, beat_last;

    always_comb begin
        cyc_ext  = {1'b0, cyc_ns_q};
        ts_end   = {1'b0, cfg_ts_start_ns} + {1'b0, cfg_ts_len_ns};
        guard_lo = (cfg_ts_start_ns >= cfg_guard_ns) ? (cfg_ts_start_ns - cfg_guard_ns) : '0;
        in_win   = (cyc_ns_q >= cfg_ts_start_ns) && (cyc_ext < ts_end);
        in_guard = (cyc_ns_q >= guard_lo) && (cyc_ns_q < cfg_ts_start_ns);
        ts_open  = !running_q || in_win;
        be_open  = !running_q || (!in_win && !in_guard);
    end

    always_comb begin
        next_ns       = cyc_ext + STEP;
        running_d     = running_q;
        cyc_ns_d      = cyc_ns_q;
        cycle_start_d = 1'b0;
        if (!cfg_enable) begin
            running_d = 1'b0;
            cyc_ns_d  = '0;
        end else if (!running_q) begin
            if (rtc_timer_in >= cfg_base_time) begin
                running_d     = 1'b1;
                cyc_ns_d      = '0;
                cycle_start_d = 1'b1;
            end
        end else if (next_ns >= {1'b0, cfg_cycle_ns}) begin
            cyc_ns_d      = CNT_W'(next_ns - {1'b0, cfg_cycle_ns});
            cycle_start_d = 1'b1;
        end else begin
            cyc_ns_d = next_ns[CNT_W-1:0];
        end
    end

    // Granted queue is passed straight through; the other queue sees tready=0.
    always_comb begin
        m_tdata     = '0;
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;
        s_ts_tready = 1'b0;
        s_be_tready = 1'b0;
        if (state_q == SEND_TS) begin
            m_tdata     = s_ts_tdata;
            m_tvalid    = s_ts_tvalid;
            m_tlast     = s_ts_tlast;
            s_ts_tready = m_tready;
        end else if (state_q == SEND_BE) begin
            m_tdata     = s_be_tdata;
            m_tvalid    = s_be_tvalid;
            m_tlast     = s_be_tlast;
            s_be_tready = m_tready;
        end
    end

    always_comb begin
        state_d    = state_q;
        ts_cnt_d   = ts_cnt_q;
        be_cnt_d   = be_cnt_q;
        ovr_cnt_d  = ovr_cnt_q;
        ovr_seen_d = ovr_seen_q;
        gate_vld_d = 1'b1;
        win_prev_d = running_q && in_win;
        beat_last  = m_tvalid && m_tready && m_tlast;
        case (state_q)
            IDLE: begin
                ovr_seen_d = 1'b0;
                if (s_ts_tvalid && ts_open) begin
                    state_d = SEND_TS;
                end else if (s_be_tvalid && be_open) begin
                    state_d = SEND_BE;
                end
            end
            SEND_TS: begin
                // Window closing under a running frame: counted once, frame not cut.
                if (win_prev_q && running_q && !in_win && !ovr_seen_q) begin
                    ovr_cnt_d  = ovr_cnt_q + 16'd1;
                    ovr_seen_d = 1'b1;
                end
                if (beat_last) begin
                    state_d  = IDLE;
                    ts_cnt_d = ts_cnt_q + 16'd1;
                end
            end
            SEND_BE: begin
                if (beat_last) begin
                    state_d  = IDLE;
                    be_cnt_d = be_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge tx_mac_aclk) begin
        if (!tx_mac_resetn) begin
            state_q       <= IDLE;
            running_q     <= 1'b0;
            cyc_ns_q      <= '0;
            cycle_start_q <= 1'b0;
            gate_vld_q    <= 1'b0;
            win_prev_q    <= 1'b0;
            ovr_seen_q    <= 1'b0;
            ts_cnt_q      <= '0;
            be_cnt_q      <= '0;
            ovr_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            running_q     <= running_d;
            cyc_ns_q      <= cyc_ns_d;
            cycle_start_q <= cycle_start_d;
            gate_vld_q    <= gate_vld_d;
            win_prev_q    <= win_prev_d;
            ovr_seen_q    <= ovr_seen_d;
            ts_cnt_q      <= ts_cnt_d;
            be_cnt_q      <= be_cnt_d;
            ovr_cnt_q     <= ovr_cnt_d;
        end
    end

    // Gate outputs read 0 while in reset and track the live gates afterwards.
    assign ts_gate_open   = gate_vld_q & ts_open;
    assign be_gate_open   = gate_vld_q & be_open;
    assign cycle_start    = cycle_start_q;
    assign ts_frame_cnt   = ts_cnt_q;
    assign be_frame_cnt   = be_cnt_q;
    assign ts_overrun_cnt = ovr_cnt_q;

endmodule

// File: doc/tsn_tx_gate_sched.md
# tsn_tx_gate_sched

Time-aware transmit scheduler (802.1Qbv-style, two traffic classes) sitting between the client TX FIFOs and the timestamping/MAC TX byte stream. It arbitrates frame-atomically between a time-sensitive (TS) AXI-Stream queue and a best-effort (BE) queue. A programmable gate cycle drives the arbitration: a TS window, and a guard band that keeps BE frames from starting just before the TS window opens. Gate and frame statistics are exported for the AXI-Lite register bank.

## Interface
- NS_PER_CLK, 8: nanoseconds added to the cycle counter per clock (125 MHz).
- CNT_W, 32: width of the cycle-time counter and gate config fields.
- tx_mac_aclk  in  1  sole clock; all logic on rising edge.
- tx_mac_resetn  in  1  reset; synchronous, active-low.
- rtc_timer_in  in  64  RTC ns time, already in tx_mac_aclk domain.
- cfg_enable  in  1  1 = gated scheduling, 0 = strict priority TS>BE.
- cfg_base_time  in  64  RTC time at which the first gate cycle starts.
- cfg_cycle_ns  in  CNT_W  gate cycle length (≥ 2*NS_PER_CLK).
- cfg_ts_start_ns  in  CNT_W  TS window offset in the cycle.
- cfg_ts_len_ns  in  CNT_W  TS window length; ts_start+ts_len ≤ cycle.
- cfg_guard_ns  in  CNT_W  BE guard band before TS window.
- s_ts_tdata/tvalid/tlast  in  8/1/1,  s_ts_tready  out  1: TS queue stream.
- s_be_tdata/tvalid/tlast  in  8/1/1,  s_be_tready  out  1: BE queue stream.
- m_tdata/tvalid/tlast  out  8/1/1,  m_tready  in  1: stream to TSU/MAC.
- ts_gate_open, be_gate_open  out  1  current gate state.
- cycle_start  out  1  one-clock pulse at each cycle start.
- ts_frame_cnt, be_frame_cnt  out  16  completed frames, wrap at 0xFFFF→0.
- ts_overrun_cnt  out  16  TS frames still sending when TS window closed.

## Operation
- Config inputs must be held static while cfg_enable=1; changes take effect only via a disable/enable cycle.
- Run control: cfg_enable=0 → running=0, cyc_ns=0. cfg_enable=1 and !running → wait until rtc_timer_in ≥ cfg_base_time. When that condition holds, set running=1 and cyc_ns=0, and pulse cycle_start on the following clock.
- Cycle counter (running): next = cyc_ns+NS_PER_CLK. If next ≥ cfg_cycle_ns, cyc_ns ← next−cfg_cycle_ns and cycle_start pulses; otherwise cyc_ns ← next. All sums are computed in CNT_W+1 bits, with no overflow.
- Gates (combinational from registered cyc_ns):
  - ts_open = !running | (cyc_ns ≥ ts_start & cyc_ns < ts_start+ts_len).
  - guard = cyc_ns ≥ sat0(ts_start−guard) & cyc_ns < ts_start, where sat0 clips the difference at 0.
  - be_open = !running | (!ts_open_window & !guard).
- FSM, states IDLE, SEND_TS, SEND_BE:
  - IDLE: if s_ts_tvalid & ts_open → SEND_TS; else if s_be_tvalid & be_open → SEND_BE.
  - SEND_x: m_* = s_x_*, s_x_tready = m_tready, other tready = 0. On m_tvalid&m_tready&m_tlast → IDLE and increment x frame counter.
- Frames are atomic: a gate closing mid-frame never cuts a frame.
- In SEND_TS, a falling edge of the TS window (running) increments ts_overrun_cnt, at most once per frame.
- Disabling mid-frame: the current frame completes; afterwards strict priority applies.
- Reset values: state IDLE, running 0, cyc_ns 0. All outputs 0 (m_tvalid, both treadys, cycle_start, counters). Gate outputs follow !running, so both read 1 from the first clock after reset.

## Timing
- Grant decision is registered: the first m_tvalid comes 1 clock after an IDLE cycle in which a qualifying tvalid is seen.
- There is at least 1 idle clock (m_tvalid=0) between consecutive frames.
- In SEND states, data path is combinational pass-through with zero latency. tready is combinational from m_tready.
- m_tvalid is held while m_tready=0. Data must not change (inherited from source AXIS compliance).
- Gate outputs change on the clock after cyc_ns crosses a boundary. cycle_start is high in the same clock cyc_ns wraps to the new value.
- Simultaneous TS/BE valid with both gates open (disabled mode): TS wins.

## Test plan
- Reset/disabled: hold resetn=0 for 4 clocks, then release with enable=0. Required: all outputs 0 during reset; then gates=1. A 64-byte BE frame passes with m_tvalid 1 clock after s_be_tvalid and be_frame_cnt=1.
- Cycle timing: NS_PER_CLK=8, cycle=1000, ts_start=400, ts_len=200, guard=120, base_time=5000. Required: first cycle_start when RTC ≥5000, then a pulse every 125 clocks. ts_gate_open high for clocks 50..74 of each cycle; be_gate_open low for clocks 35..74.
- Guard band: with the same config, present a BE frame at cyc_ns=288. Required: the frame is not started until cyc_ns ≥600. A TS frame pending at the same time starts at cyc_ns=400.
- Overrun: start a 100-byte TS frame at cyc_ns=560 with m_tready=1. Required: the frame completes intact, ts_overrun_cnt=1, and BE is blocked until the TS frame's tlast.
- Backpressure/priority: disabled mode, both queues valid, m_tready toggling 50%. Required: the TS frame goes first, byte-exact, then the BE frame; tready is never asserted to the non-granted queue.
- Disable mid-frame: drop cfg_enable during a BE frame. Required: the frame completes, running=0 and gates=1 on the next clock, and cyc_ns restarts at 0 on re-enable after base_time.
